// File: rtl/fma_result_pack_if.sv
// fma_result_pack_if: rounder-to-writeback bundle for the FP32 FMA result pack stage
interface fma_result_pack_if #(
  parameter int PARM_EXP   = 8,
  parameter int PARM_MANT  = 23,
  parameter int PARM_TAG   = 8,
  parameter int PARM_CNT_W = 16
);
  logic                          In_valid_i;
  logic                          In_ready_o;
  logic                          Sign_result_i;
  logic [PARM_EXP-1:0]           Exp_result_i;
  logic [PARM_MANT-1:0]          Mant_result_i;
  logic                          Invalid_i;
  logic                          Overflow_i;
  logic                          Underflow_i;
  logic                          Inexact_i;
  logic [PARM_TAG-1:0]           Tag_i;
  logic                          Out_valid_o;
  logic                          Out_ready_i;
  logic [PARM_EXP+PARM_MANT:0]   Result_o;
  logic [4:0]                    Flags_o;
  logic [PARM_TAG-1:0]           Tag_o;
  logic                          Fflags_clr_i;
  logic [4:0]                    Fflags_o;
  logic [PARM_CNT_W-1:0]         Result_cnt_o;
  modport master (
    output In_valid_i, Sign_result_i, Exp_result_i, Mant_result_i, Invalid_i, Overflow_i,
           Underflow_i, Inexact_i, Tag_i, Out_ready_i, Fflags_clr_i,
    input  In_ready_o, Out_valid_o, Result_o, Flags_o, Tag_o, Fflags_o, Result_cnt_o
  );
  modport slave (
    input  In_valid_i, Sign_result_i, Exp_result_i, Mant_result_i, Invalid_i, Overflow_i,
           Underflow_i, Inexact_i, Tag_i, Out_ready_i, Fflags_clr_i,
    output In_ready_o, Out_valid_o, Result_o, Flags_o, Tag_o, Fflags_o, Result_cnt_o
  );
endinterface

// File: rtl/fma_result_pack.sv
// fma_result_pack: 2-entry skid buffer packing rounded FMA results, with sticky fflags and retire counter
module fma_result_pack #(
  parameter int PARM_EXP   = 8,
  parameter int PARM_MANT  = 23,
  parameter int PARM_TAG   = 8,
  parameter int PARM_CNT_W = 16
) (
  input logic clk,
  input logic rst_n,
  fma_result_pack_if.slave io
);
  localparam int W = PARM_EXP + PARM_MANT + 1;
  localparam int E = W + 5 + PARM_TAG;
  logic [E-1:0] mem_q [2];
  logic [E-1:0] mem_d [2];
  logic wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [1:0] count_q, count_d;
  logic in_ready_q, in_ready_d, out_valid_q, out_valid_d;
  logic [4:0] fflags_q, fflags_d;
  logic [PARM_CNT_W-1:0] cnt_q, cnt_d;
  logic push, pop;
  logic [W-1:0] word;
  logic [4:0] flg;
  always_comb begin
    push = io.In_valid_i & in_ready_q;
    pop = out_valid_q & io.Out_ready_i;
    word = io.Invalid_i ? {1'b0, {PARM_EXP{1'b1}}, 1'b1, {(PARM_MANT-1){1'b0}}}
                        : {io.Sign_result_i, io.Exp_result_i, io.Mant_result_i};
    flg = {io.Invalid_i, 1'b0, io.Overflow_i, io.Underflow_i, io.Inexact_i};
    mem_d = mem_q;
    mem_d[wr_ptr_q] = push ? {word, flg, io.Tag_i} : mem_q[wr_ptr_q];
    wr_ptr_d = wr_ptr_q ^ push;
    rd_ptr_d = rd_ptr_q ^ pop;
    count_d = count_q + {1'b0, push} - {1'b0, pop};
    // clear wipes history but keeps the flags of a result accepted this cycle
    fflags_d = (io.Fflags_clr_i ? 5'd0 : fflags_q) | (push ? flg : 5'd0);
    cnt_d = cnt_q + PARM_CNT_W'(pop);
    in_ready_d = count_d != 2'd2;
    out_valid_d = count_d != 2'd0;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_q <= '{default: '0};
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q <= 2'd0;
      in_ready_q <= 1'b0;
      out_valid_q <= 1'b0;
      fflags_q <= 5'd0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
      in_ready_q <= in_ready_d;
      out_valid_q <= out_valid_d;
      fflags_q <= fflags_d;
      cnt_q <= cnt_d;
    end
  end
  assign io.In_ready_o = in_ready_q;
  assign io.Out_valid_o = out_valid_q;
  assign {io.Result_o, io.Flags_o, io.Tag_o} = mem_q[rd_ptr_q];
  assign io.Fflags_o = fflags_q;
  assign io.Result_cnt_o = cnt_q;
endmodule
